// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: one load/store at a time over a
// valid/ready request handshake, fixed access latency, valid/ready response.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | req_ready=1, waiting for a request; captures fields on accept
// WAIT  | latency countdown; access is performed on the edge leaving WAIT
// RESP  | rsp_valid=1, outputs held until rsp_ready
//
// The counter is loaded with LATENCY-1 and WAIT exits on the edge where it
// reads 0, so rsp_valid rises exactly LATENCY edges after acceptance for
// every legal LATENCY (1 included, which spends a single cycle in WAIT).
module data_memory_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        capture, fire;

  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] memory [DEPTH];

  logic [IW-1:0] idx;
  logic [31:0]   word_rd;
  logic          f3_ok, misaligned, out_of_range, err;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;
  logic [31:0]   store_word;

  assign idx       = addr_q[IW+1:2];
  assign word_rd   = memory[idx];
  assign req_ready = (state == IDLE) && reset;
  assign rsp_valid = (state == RESP);

  // Request legality, judged on the captured fields
  always_comb begin
    f3_ok        = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    if (wr_q) f3_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
    else      f3_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                      (f3_q == 3'b100) || (f3_q == 3'b101);
    if ((f3_q[1:0] == 2'b01) && addr_q[0])           misaligned = 1'b1;
    if ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)) misaligned = 1'b1;
    out_of_range = (addr_q[31:2] >= 30'(DEPTH));
    err = !f3_ok || misaligned || out_of_range;
  end

  // Lane selection and extension for loads, lane merge for stores
  always_comb begin
    byte_sel   = 8'h00;
    half_sel   = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
    load_data  = 32'h0;
    store_word = word_rd;
    case (addr_q[1:0])
      2'b00:   byte_sel = word_rd[7:0];
      2'b01:   byte_sel = word_rd[15:8];
      2'b10:   byte_sel = word_rd[23:16];
      default: byte_sel = word_rd[31:24];
    endcase
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = word_rd;
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
    case (f3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'b00:   store_word[7:0]   = wdata_q[7:0];
          2'b01:   store_word[15:8]  = wdata_q[7:0];
          2'b10:   store_word[23:16] = wdata_q[7:0];
          default: store_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) store_word[31:16] = wdata_q[15:0];
        else           store_word[15:0]  = wdata_q[15:0];
      end
      default: store_word = wdata_q;
    endcase
  end

  // Next-state, counter and capture/access strobes
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          capture  = 1'b1;
          cnt_nx   = 4'(LATENCY - 1);
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          fire     = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counter, captured request and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) begin
        wr_q    <= req_write;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (fire) begin
        rsp_error <= err;
        rsp_rdata <= (err || wr_q) ? 32'h0 : load_data;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_error <= 1'b0;
        rsp_rdata <= 32'h0;
      end
    end
  end

  // Storage array; not reset, so a store committed before reset survives it
  always_ff @(posedge clk) begin
    if (fire && wr_q && !err) memory[idx] <= store_word;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: LATENCY=2 instance for the
// access/error/backpressure cases, LATENCY=3 instance for mid-op reset.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic        sel;
  logic        req_valid, req_write, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        rr_a, rv_a, re_a, rr_b, rv_b, re_b;
  logic [31:0] rd_a, rd_b;

  logic        o_req_ready, o_rsp_valid, o_rsp_error;
  logic [31:0] o_rsp_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH(32), .LATENCY(2)) dut (
    .clk(clk), .reset(reset_a),
    .req_valid(req_valid && !sel), .req_ready(rr_a),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready && !sel),
    .rsp_rdata(rd_a), .rsp_error(re_a)
  );

  data_memory_responder #(.DEPTH(32), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset_b),
    .req_valid(req_valid && sel), .req_ready(rr_b),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready && sel),
    .rsp_rdata(rd_b), .rsp_error(re_b)
  );

  assign o_req_ready = sel ? rr_b : rr_a;
  assign o_rsp_valid = sel ? rv_b : rv_a;
  assign o_rsp_error = sel ? re_b : re_a;
  assign o_rsp_rdata = sel ? rd_b : rd_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; caller is just past an edge with req_ready high.
  task automatic run(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    logic [31:0] rd;
    logic er;
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = o_rsp_rdata;
    er = o_rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".error"}, {31'h0, er}, {31'h0, exp_err});
    check({tag, ".ready_after"}, {31'h0, o_req_ready}, 32'h1);
  endtask

  initial begin
    sel = 1'b0; reset_a = 1'b0; reset_b = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", {31'h0, o_req_ready}, 32'h0);
    check("rst.rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    check("rst.rsp_rdata", o_rsp_rdata, 32'h0);
    check("rst.rsp_error", {31'h0, o_rsp_error}, 32'h0);
    reset_a = 1'b1; reset_b = 1'b1;
    @(posedge clk); #1;
    check("rel.req_ready", {31'h0, o_req_ready}, 32'h1);

    // Initialise word 3, then loads with each extension
    run("sw_init", 1'b1, 3'b010, 32'h0C, 32'h8899AABB, 32'h0, 1'b0, 2);
    run("lb_0e",   1'b0, 3'b000, 32'h0E, 32'h0, 32'hFFFFFF99, 1'b0, 2);
    run("lbu_0e",  1'b0, 3'b100, 32'h0E, 32'h0, 32'h00000099, 1'b0, 2);
    run("lh_0c",   1'b0, 3'b001, 32'h0C, 32'h0, 32'hFFFFAABB, 1'b0, 2);
    run("lw_0c",   1'b0, 3'b010, 32'h0C, 32'h0, 32'h8899AABB, 1'b0, 2);

    // Partial stores
    run("sb_0d",   1'b1, 3'b000, 32'h0D, 32'h00000011, 32'h0, 1'b0, 2);
    run("lw_sb",   1'b0, 3'b010, 32'h0C, 32'h0, 32'h889911BB, 1'b0, 2);
    run("sh_0e",   1'b1, 3'b001, 32'h0E, 32'h00002233, 32'h0, 1'b0, 2);
    run("lw_sh",   1'b0, 3'b010, 32'h0C, 32'h0, 32'h223311BB, 1'b0, 2);
    run("lh_0e",   1'b0, 3'b001, 32'h0E, 32'h0, 32'h00002233, 1'b0, 2);
    run("lb_0d",   1'b0, 3'b000, 32'h0D, 32'h0, 32'h00000011, 1'b0, 2);

    // Errors: misaligned, out of range, illegal funct3
    run("lw_mis",  1'b0, 3'b010, 32'h0D, 32'h0, 32'h0, 1'b1, 2);
    run("sh_mis",  1'b1, 3'b001, 32'h0F, 32'h0000FFFF, 32'h0, 1'b1, 2);
    run("sb_bad",  1'b1, 3'b100, 32'h0C, 32'h000000EE, 32'h0, 1'b1, 2);
    run("ld_011",  1'b0, 3'b011, 32'h0C, 32'h0, 32'h0, 1'b1, 2);
    run("lw_oor",  1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 1'b1, 2);
    run("lw_keep", 1'b0, 3'b010, 32'h0C, 32'h0, 32'h223311BB, 1'b0, 2);

    // Backpressure: response held for 5 cycles, new request ignored
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0C; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      check("bp.rsp_valid", {31'h0, o_rsp_valid}, 32'h1);
      check("bp.rsp_rdata", o_rsp_rdata, 32'h223311BB);
      check("bp.req_ready", {31'h0, o_req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp.ready_after", {31'h0, o_req_ready}, 32'h1);
    check("bp.valid_after", {31'h0, o_rsp_valid}, 32'h0);
    run("bp_keep", 1'b0, 3'b010, 32'h0C, 32'h0, 32'h223311BB, 1'b0, 2);

    // rsp_ready held high early: response lasts one cycle
    rsp_ready = 1'b1;
    req_write = 1'b0; req_funct3 = 3'b101; req_addr = 32'h0E; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("early.n1_valid", {31'h0, o_rsp_valid}, 32'h0);
    @(posedge clk); #1;
    check("early.n2_valid", {31'h0, o_rsp_valid}, 32'h1);
    check("early.n2_rdata", o_rsp_rdata, 32'h00002233);
    @(posedge clk); #1;
    check("early.n3_valid", {31'h0, o_rsp_valid}, 32'h0);
    check("early.n3_ready", {31'h0, o_req_ready}, 32'h1);
    rsp_ready = 1'b0;

    // LATENCY=3 instance: reset one cycle after accepting a store
    sel = 1'b1;
    run("l3_sw_init", 1'b1, 3'b010, 32'h10, 32'h01234567, 32'h0, 1'b0, 3);
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
    req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b0;
    #1;
    check("l3rst.rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    check("l3rst.req_ready", {31'h0, o_req_ready}, 32'h0);
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
    check("l3rel.req_ready", {31'h0, o_req_ready}, 32'h1);
    check("l3rel.rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    run("l3_lw_keep", 1'b0, 3'b010, 32'h10, 32'h0, 32'h01234567, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
